// File: rtl/ovl_multi_pkg.sv
// Shared types and helpers for the multi-channel OVL "always" checker family.
package ovl_multi_pkg;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    ARMED   = 2'd1,
    TRIPPED = 2'd2
  } ovl_state_e;

  localparam int NUM_CH_DEF      = 4;
  localparam int HOLDOFF_CYC_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  // Increment that sticks at max_val instead of wrapping (counters up to 32 bits).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/ovl_prio_enc.sv
// Combinational lowest-set-bit encoder: idx is the lowest set position of req, valid if any bit set.
module ovl_prio_enc #(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/ovl_always_multi.sv
// Multi-channel OVL "always" checker with settle masking, sticky capture and trip state.
// Optional saturating violation counter enabled by defining OVL_ALWAYS_MULTI_COUNT_EN.
module ovl_always_multi
  import ovl_multi_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int HOLDOFF_CYC = HOLDOFF_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int IDX_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] enable,
  input  logic [NUM_CH-1:0] test_expr,
  input  logic              prevConfigInvalid,
  input  logic              clear,
  output logic [NUM_CH-1:0] fire_vec,
  output logic              out,
  output logic [NUM_CH-1:0] sticky_vec,
  output logic              tripped,
  output logic [IDX_W-1:0]  first_idx,
  output logic [CNT_W-1:0]  fire_count,
  output logic [1:0]        state_dbg
);

  ovl_state_e  state;
  logic [7:0]  hold_cnt;
  logic [IDX_W-1:0] low_idx;
  logic        any_fire;
  logic        check_ok;

  assign check_ok  = ~prevConfigInvalid & (state != HOLDOFF) & ~rst;
  assign fire_vec  = enable & ~test_expr & {NUM_CH{check_ok}};
  assign out       = |fire_vec;
  assign state_dbg = state;

  ovl_prio_enc #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_prio (
    .req   (fire_vec),
    .idx   (low_idx),
    .valid (any_fire)
  );

  // Valid/ready does not apply here: every input is sampled every cycle, clear is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOLDOFF;
      hold_cnt   <= 8'(HOLDOFF_CYC);
      sticky_vec <= '0;
      first_idx  <= '0;
      tripped    <= 1'b0;
    end else begin
      case (state)
        HOLDOFF: begin
          tripped <= 1'b0;
          if (prevConfigInvalid) begin
            hold_cnt <= 8'(HOLDOFF_CYC);
          end else if (hold_cnt == 8'd0) begin
            state <= ARMED;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
          if (clear) begin
            sticky_vec <= '0;
            first_idx  <= '0;
          end
        end
        ARMED, TRIPPED: begin
          if (prevConfigInvalid) begin
            // Captured history survives a config drop; only the state is reset.
            state    <= HOLDOFF;
            hold_cnt <= 8'(HOLDOFF_CYC);
            tripped  <= 1'b0;
            if (clear) begin
              sticky_vec <= '0;
              first_idx  <= '0;
            end
          end else if (any_fire) begin
            state   <= TRIPPED;
            tripped <= 1'b1;
            if (clear) begin
              sticky_vec <= fire_vec;
              first_idx  <= low_idx;
            end else begin
              sticky_vec <= sticky_vec | fire_vec;
              if (state == ARMED) first_idx <= low_idx;
            end
          end else if (clear) begin
            state      <= ARMED;
            tripped    <= 1'b0;
            sticky_vec <= '0;
            first_idx  <= '0;
          end
        end
        default: begin
          state    <= HOLDOFF;
          hold_cnt <= 8'(HOLDOFF_CYC);
          tripped  <= 1'b0;
        end
      endcase
    end
  end

`ifdef OVL_ALWAYS_MULTI_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts violating cycles, not violating channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= out ? CNT_W'(1) : '0;
    end else if (out) begin
      cnt_q <= CNT_W'(sat_inc(32'(cnt_q), 32'({CNT_W{1'b1}})));
    end
  end

  assign fire_count = cnt_q;
`else
  assign fire_count = '0;
`endif

endmodule

// File: tb/tb_ovl_always_multi.sv
// Directed self-checking bench for ovl_always_multi (NUM_CH=4, HOLDOFF_CYC=2, CNT_W=3).
module tb_ovl_always_multi;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 3;
  localparam int IDX_W  = 2;
`ifdef OVL_ALWAYS_MULTI_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] enable;
  logic [NUM_CH-1:0] test_expr;
  logic              prevConfigInvalid;
  logic              clear;
  logic [NUM_CH-1:0] fire_vec;
  logic              out;
  logic [NUM_CH-1:0] sticky_vec;
  logic              tripped;
  logic [IDX_W-1:0]  first_idx;
  logic [CNT_W-1:0]  fire_count;
  logic [1:0]        state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  ovl_always_multi #(.NUM_CH(NUM_CH), .HOLDOFF_CYC(2), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .test_expr         (test_expr),
    .prevConfigInvalid (prevConfigInvalid),
    .clear             (clear),
    .fire_vec          (fire_vec),
    .out               (out),
    .sticky_vec        (sticky_vec),
    .tripped           (tripped),
    .first_idx         (first_idx),
    .fire_count        (fire_count),
    .state_dbg         (state_dbg)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp)
      else begin
        n_bad++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic logic [31:0] ecnt(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic check_regs(input string tag, input logic [3:0] s, input int fi,
                            input bit tr, input int cnt);
    check({tag, ".sticky"},  32'(sticky_vec), 32'(s));
    check({tag, ".first"},   32'(first_idx),  32'(fi));
    check({tag, ".tripped"}, 32'(tripped),    32'(tr));
    check({tag, ".count"},   32'(fire_count), ecnt(cnt));
  endtask

  initial begin
    rst = 1'b1; enable = 4'hF; test_expr = 4'h0; prevConfigInvalid = 1'b0; clear = 1'b0;

    // Reset: violations present but forced off.
    repeat (3) tick();
    check("rst.fire", 32'(fire_vec), 32'h0);
    check("rst.out",  32'(out), 32'h0);
    check("rst.state", 32'(state_dbg), 32'd0);
    check_regs("rst", 4'h0, 0, 1'b0, 0);

    rst = 1'b0; test_expr = 4'hF;
    settle();
    check("hold.out0", 32'(out), 32'h0);
    tick();
    check("hold.state1", 32'(state_dbg), 32'd0);
    tick();
    check("hold.state2", 32'(state_dbg), 32'd0);
    tick();
    check("armed.state", 32'(state_dbg), 32'd1);

    // Single fire on channel 2.
    test_expr = 4'b1011;
    settle();
    check("single.fire", 32'(fire_vec), 32'h4);
    check("single.out",  32'(out), 32'h1);
    tick();
    test_expr = 4'hF;
    check_regs("single", 4'b0100, 2, 1'b1, 1);
    check("single.state", 32'(state_dbg), 32'd2);

    // Clear with no fire re-arms.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_regs("clr", 4'h0, 0, 1'b0, 0);
    check("clr.state", 32'(state_dbg), 32'd1);

    // Channels 3 and 1 together, then channel 0.
    test_expr = 4'b0101;
    settle();
    check("sim.fire", 32'(fire_vec), 32'hA);
    tick();
    check_regs("sim", 4'b1010, 1, 1'b1, 1);
    test_expr = 4'b1110;
    tick();
    test_expr = 4'hF;
    check_regs("acc", 4'b1011, 1, 1'b1, 2);

    // Clear and fire together: fire wins.
    clear = 1'b1; test_expr = 4'b0111;
    tick();
    clear = 1'b0; test_expr = 4'hF;
    check_regs("coll", 4'b1000, 3, 1'b1, 1);
    tick();
    check_regs("coll.hold", 4'b1000, 3, 1'b1, 1);

    // Config invalid for 5 cycles with channel 0 violating throughout.
    prevConfigInvalid = 1'b1; test_expr = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("pci.out%0d", i), 32'(out), 32'h0);
      tick();
    end
    check_regs("pci.keep", 4'b1000, 3, 1'b0, 1);
    check("pci.state", 32'(state_dbg), 32'd0);
    prevConfigInvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("settle.out%0d", i), 32'(out), 32'h0);
      tick();
    end
    settle();
    check("rearm.out", 32'(out), 32'h1);
    tick();
    check_regs("rearm", 4'b1001, 0, 1'b1, 2);

    // Disabled channel never fires.
    enable = 4'b1110;
    settle();
    check("dis.out", 32'(out), 32'h0);
    check("dis.fire", 32'(fire_vec), 32'h0);
    tick();
    check("dis.tripped", 32'(tripped), 32'h1);

    // Re-arm, then 10 violating cycles on all channels to saturate the counter.
    enable = 4'hF; test_expr = 4'hF; clear = 1'b1;
    tick();
    clear = 1'b0;
    check_regs("pre.sat", 4'h0, 0, 1'b0, 0);
    test_expr = 4'h0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check($sformatf("sat.cnt%0d", i), 32'(fire_count), ecnt(i > 7 ? 7 : i));
    end
    check_regs("sat", 4'hF, 0, 1'b1, 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
